// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan
// Scans a 3-digit BCD value onto a time-multiplexed, common-anode
// seven-segment display. New values are double-buffered and only swapped
// in at a frame boundary, so a digit never changes mid-frame. Supports
// leading-zero blanking, an "Err" indication and whole-display blinking.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       one-cycle strobe capturing bcd_in/err
//   bcd_in     [11:8] hundreds, [7:4] tens, [3:0] units
//   err        captured with load; shows "Err" when set
//   blank_lz   live leading-zero blanking enable
//   blink      live blink enable
//   an_n       active-low digit enables ([0] units .. [2] hundreds)
//   seg_n      active-low segments {g,f,e,d,c,b,a}
//   frame_done one-cycle pulse after each completed frame
//
// Digit-select FSM:
//   state | meaning
//   DIG_U | units digit lit (idx 0)
//   DIG_T | tens digit lit (idx 1)
//   DIG_H | hundreds digit lit (idx 2); last slot of a frame
module bcd_seg7_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] bcd_in,
    input  logic        err,
    input  logic        blank_lz,
    input  logic        blink,
    output logic [2:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        frame_done
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        DIG_U = 2'd0,
        DIG_T = 2'd1,
        DIG_H = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase_on;
    logic [11:0]   active, pending;
    logic          active_err, pend_err, pend_v;
    logic          wrap, boundary;
    logic [2:0]    an_next;
    logic [6:0]    seg_next;
    logic [3:0]    nib;
    logic          blanked;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign wrap     = (div_cnt == DIV_LAST);
    assign boundary = wrap && (state == DIG_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIG_U;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic; advances only when the digit period expires
    always_comb begin
        state_next = state;
        if (wrap) begin
            case (state)
                DIG_U:   state_next = DIG_T;
                DIG_T:   state_next = DIG_H;
                default: state_next = DIG_U;
            endcase
        end
    end

    // Double buffer. A load coinciding with the boundary bypasses pending
    // so it is shown in the very next frame rather than one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            pend_err   <= 1'b0;
            pend_v     <= 1'b0;
            active     <= '0;
            active_err <= 1'b0;
        end else if (boundary) begin
            pend_v <= 1'b0;
            if (load) begin
                active     <= bcd_in;
                active_err <= err;
            end else if (pend_v) begin
                active     <= pending;
                active_err <= pend_err;
            end
        end else if (load) begin
            pending  <= bcd_in;
            pend_err <= err;
            pend_v   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (!blink) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (boundary) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
        end
    end

    // FSM: output logic; feeds the output register so an_n/seg_n lag state by one clock
    always_comb begin
        an_next  = 3'b110;
        nib      = active[3:0];
        seg_next = 7'h7F;
        blanked  = 1'b0;
        case (state)
            DIG_T: begin
                an_next = 3'b101;
                nib     = active[7:4];
                blanked = (active[11:8] == 4'd0) && (active[7:4] == 4'd0);
            end
            DIG_H: begin
                an_next = 3'b011;
                nib     = active[11:8];
                blanked = (active[11:8] == 4'd0);
            end
            default: begin
                an_next = 3'b110;
                nib     = active[3:0];
                blanked = 1'b0;
            end
        endcase

        if (active_err) begin
            seg_next = (state == DIG_H) ? 7'h06 : 7'h2F;
        end else begin
            seg_next = decode(nib);
        end

        // Err mode always shows all three characters.
        if ((blank_lz && !active_err && blanked) || (blink && !phase_on)) begin
            an_next  = 3'b111;
            seg_next = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 3'b111;
            seg_n <= 7'h7F;
        end else begin
            an_n  <= an_next;
            seg_n <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Testbench for bcd_seg7_scan with SCAN_DIV = 4, BLINK_FRAMES = 2.
// Stimulus pushes the hand-computed digits of each frame into a queue at
// frame start; a monitor pops and samples each digit slot mid-period.
module tb_bcd_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        err = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink = 1'b0;
    logic [2:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_done;

    bcd_seg7_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .err(err),
        .blank_lz(blank_lz), .blink(blink), .an_n(an_n), .seg_n(seg_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            chk;
        logic [2:0][9:0] dig;
    } frm_t;

    frm_t sb_q[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   last_fd = -1;
    int   nframe = 0;

    localparam logic [9:0] DARK = {3'b111, 7'h7F};

    function automatic logic [9:0] u(input logic [6:0] s); return {3'b110, s}; endfunction
    function automatic logic [9:0] t(input logic [6:0] s); return {3'b101, s}; endfunction
    function automatic logic [9:0] h(input logic [6:0] s); return {3'b011, s}; endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic frame(input logic c, input logic [9:0] d0, input logic [9:0] d1,
                         input logic [9:0] d2);
        frm_t e;
        int   n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        if (!frame_done) check("frame_done timeout", 32'd0, 32'd1);
        e.chk    = c;
        e.dig[0] = d0;
        e.dig[1] = d1;
        e.dig[2] = d2;
        sb_q.push_back(e);
    endtask

    // Caller sits at a negedge; returns 1 after the capturing posedge.
    task automatic do_load(input logic [11:0] v, input logic e);
        load   = 1'b1;
        bcd_in = v;
        err    = e;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_fd = -1;
        end else if (frame_done) begin
            if (last_fd >= 0) check("frame period", 32'(cyc - last_fd), 32'd12);
            last_fd = cyc;
        end
    end

    // Monitor: digit d of a frame is visible from cycle 1+4d; sample at 2+4d.
    initial begin
        frm_t e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_done) begin
                @(negedge clk);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    nframe++;
                    for (int d = 0; d < 3; d++) begin
                        repeat ((d == 0) ? 1 : 4) @(negedge clk);
                        if (e.chk)
                            check($sformatf("frame %0d digit %0d {an_n,seg_n}", nframe, d),
                                  32'({an_n, seg_n}), 32'(e.dig[d]));
                    end
                end
            end
        end
    end

    initial begin
        int i;
        // 1. reset
        repeat (3) @(negedge clk);
        check("reset an_n", 32'(an_n), 32'h7);
        check("reset seg_n", 32'(seg_n), 32'h7F);
        check("reset frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        do_load(12'h123, 1'b0);
        frame(1'b1, u(7'h30), t(7'h24), h(7'h79));
        frame(1'b1, u(7'h30), t(7'h24), h(7'h79));

        // 2. leading-zero blanking
        do_load(12'h005, 1'b0);
        blank_lz = 1'b1;
        frame(1'b1, u(7'h12), DARK, DARK);
        repeat (11) @(negedge clk);
        blank_lz = 1'b0;
        frame(1'b1, u(7'h12), t(7'h40), h(7'h40));

        // 3. last load wins; load on boundary takes effect next frame
        repeat (2) @(negedge clk);
        do_load(12'h456, 1'b0);
        repeat (2) @(negedge clk);
        do_load(12'h789, 1'b0);
        frame(1'b1, u(7'h10), t(7'h00), h(7'h78));
        repeat (11) @(negedge clk);
        do_load(12'h321, 1'b0);
        frame(1'b1, u(7'h79), t(7'h24), h(7'h30));

        // 4. Err ignores blanking; then A-F dash
        do_load(12'h000, 1'b1);
        blank_lz = 1'b1;
        frame(1'b1, u(7'h2F), t(7'h2F), h(7'h06));
        do_load(12'h0A9, 1'b0);
        repeat (11) @(negedge clk);
        blank_lz = 1'b0;
        frame(1'b1, u(7'h10), t(7'h3F), h(7'h40));

        // 5. blink: counter 0->1 then wraps, so two more lit frames first
        blink = 1'b1;
        frame(1'b1, u(7'h10), t(7'h3F), h(7'h40));
        frame(1'b1, DARK, DARK, DARK);
        frame(1'b1, DARK, DARK, DARK);
        frame(1'b1, u(7'h10), t(7'h3F), h(7'h40));
        frame(1'b1, u(7'h10), t(7'h3F), h(7'h40));
        frame(1'b0, DARK, DARK, DARK);
        repeat (2) @(negedge clk);
        check("blink off dark", 32'({an_n, seg_n}), 32'(DARK));
        blink = 1'b0;
        @(negedge clk);
        check("blink drop lit next cycle", 32'({an_n, seg_n}), 32'(u(7'h10)));
        frame(1'b1, u(7'h10), t(7'h3F), h(7'h40));

        // 6. async reset while idx = 1
        frame(1'b0, DARK, DARK, DARK);
        repeat (5) @(negedge clk);
        check("pre-reset tens lit", 32'(an_n), 32'h5);
        rst_n = 1'b0;
        #1;
        check("mid reset an_n", 32'(an_n), 32'h7);
        check("mid reset seg_n", 32'(seg_n), 32'h7F);
        check("mid reset frame_done", 32'(frame_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i = 0;
        do begin
            @(negedge clk);
            i++;
            if (i == 1) check("restart units of 000", 32'({an_n, seg_n}), 32'(u(7'h40)));
        end while (!frame_done && i < 30);
        check("restart frame length", 32'(i), 32'd12);
        frame(1'b1, u(7'h40), t(7'h40), h(7'h40));

        repeat (14) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
